rf_wb_arbiter: RTL and testbench
================================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter: STARVE_MAX, default 4, consecutive lost-arbitration cycles after which the LL requester wins once (legal range 1..15).
REQ-002 ARB_CLK  input  1  single clock; all state updates on posedge; the register file samples WB_* on the following negedge.
REQ-003 ARB_RST  input  1  reset, synchronous and active-high.
REQ-004 PIPE_VALID  input  1  pipeline writeback request.
REQ-005 PIPE_WA  input  5  pipeline destination register.
REQ-006 PIPE_WD  input  32  pipeline write data.
REQ-007 PIPE_READY  output  1  pipeline request accepted this cycle.
REQ-008 LL_VALID  input  1  long-latency unit (mul/div/load) writeback request.
REQ-009 LL_WA  input  5  LL destination register.
REQ-010 LL_WD  input  32  LL write data.
REQ-011 LL_READY  output  1  LL request accepted this cycle.
REQ-012 WB_EN  output  1  register file write enable.
REQ-013 WB_WA  output  5  register file write address.
REQ-014 WB_WD  output  32  register file write data.
REQ-015 INIT_DONE  output  1  register clear sequence complete; requesters served.

Function
REQ-016 States SHALL be ST_INIT and ST_RUN; ST_INIT SHALL be entered on reset.
REQ-017 ST_INIT: an internal 5-bit counter SHALL start at 1; each cycle it SHALL drive WB_EN=1, WB_WA=counter, WB_WD=0, and increment.
REQ-018 ST_INIT: after the cycle that writes address 31, the FSM SHALL move to ST_RUN; exactly 31 clear writes, first on the cycle after reset deasserts.
REQ-019 INIT_DONE SHALL be 0 in ST_INIT and 1 in ST_RUN; PIPE_READY and LL_READY SHALL be 0 in ST_INIT.
REQ-020 ST_RUN: READY outputs SHALL be combinational from VALIDs and the starvation counter; at most one READY high per cycle.
REQ-021 Default priority: PIPE_VALID=1 grants PIPE; otherwise LL_VALID=1 grants LL.
REQ-022 A 4-bit starvation counter SHALL increment each cycle LL_VALID=1 and LL is not granted, and clear on LL grant or LL_VALID=0.
REQ-023 When the counter equals STARVE_MAX and LL_VALID=1, LL SHALL be granted and PIPE_READY SHALL be 0 that cycle.
REQ-024 A granted request SHALL appear on WB_WA/WB_WD with WB_EN=1 on the cycle after the grant (one-cycle registered latency).
REQ-025 A granted request with WA=0 SHALL complete its handshake but produce WB_EN=0, WB_WA=0, WB_WD=0.
REQ-026 Cycles with no grant SHALL produce WB_EN=0, WB_WA=0, WB_WD=0 on the next cycle.
REQ-027 Simultaneous requests to the same WA SHALL be written in grant order; the later write wins.
REQ-028 Requesters SHALL hold VALID/WA/WD stable until READY; the block SHALL not buffer ungranted requests.

Reset
REQ-029 ARB_RST=1 SHALL force, at the next posedge: state ST_INIT, clear counter=1, starvation counter=0, WB_EN=0, WB_WA=0, WB_WD=0, INIT_DONE=0.
REQ-030 While ARB_RST=1, PIPE_READY and LL_READY SHALL be 0.
REQ-031 Reset asserted mid-INIT or mid-RUN SHALL abandon pending output and restart the full 31-write clear sequence.

Structure
REQ-032 Package arb_pkg SHALL hold the state enum (ST_INIT, ST_RUN), NUM_REGS=32, ADDR_W=5, DATA_W=32.
REQ-033 The starvation counter SHALL be a sub-module arb_starve_cnt (inputs: clk, rst, lose, win; output: count); all else in rf_wb_arbiter.

Verification
REQ-034 Deassert reset -> WB_EN=1 for 31 cycles, WB_WA=1..31, WB_WD=0; INIT_DONE=1 on cycle 32; READYs 0 throughout.
REQ-035 RUN, PIPE_VALID=1 WA=5 WD=0xDEADBEEF -> PIPE_READY=1 same cycle; next cycle WB_EN=1 WB_WA=5 WB_WD=0xDEADBEEF.
REQ-036 PIPE_VALID and LL_VALID held 1, STARVE_MAX=4 -> PIPE granted 4 cycles, LL granted cycle 5, counter back to 0.
REQ-037 PIPE_VALID=1 WA=0 WD=0x1234 -> PIPE_READY=1; next cycle WB_EN=0, WB_WA=0, WB_WD=0.
REQ-038 Assert ARB_RST at RUN cycle 10 with LL pending -> next cycle WB_EN=0, INIT_DONE=0; after deassert, full 31-write clear reruns.
REQ-039 PIPE WA=7 WD=0xA and LL WA=7 WD=0xB together -> WB writes 0xA then 0xB on consecutive cycles; x7 ends 0xB.

Source files
------------

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and sizes for the register-file writeback arbiter.
package arb_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int STARVE_W = 4;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
  } wb_word_t;

  // x0 is hardwired: a write to it is accepted but never reaches the file.
  function automatic wb_word_t wb_write(input logic [ADDR_W-1:0] wa,
                                        input logic [DATA_W-1:0] wd);
    wb_word_t w;
    w.en = (wa != '0);
    w.wa = w.en ? wa : '0;
    w.wd = w.en ? wd : '0;
    return w;
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Requester and register-file side signals of the writeback arbiter.
interface rf_wb_arbiter_if;
  import arb_pkg::*;

  logic              PIPE_VALID;
  logic [ADDR_W-1:0] PIPE_WA;
  logic [DATA_W-1:0] PIPE_WD;
  logic              PIPE_READY;
  logic              LL_VALID;
  logic [ADDR_W-1:0] LL_WA;
  logic [DATA_W-1:0] LL_WD;
  logic              LL_READY;
  logic              WB_EN;
  logic [ADDR_W-1:0] WB_WA;
  logic [DATA_W-1:0] WB_WD;
  logic              INIT_DONE;

  modport master (
    output PIPE_VALID, PIPE_WA, PIPE_WD, LL_VALID, LL_WA, LL_WD,
    input  PIPE_READY, LL_READY, WB_EN, WB_WA, WB_WD, INIT_DONE
  );

  modport slave (
    input  PIPE_VALID, PIPE_WA, PIPE_WD, LL_VALID, LL_WA, LL_WD,
    output PIPE_READY, LL_READY, WB_EN, WB_WA, WB_WD, INIT_DONE
  );

endinterface

// File: rtl/rf_wb_arbiter_starve_cnt.sv
// Counts consecutive cycles the long-latency requester lost arbitration.
module arb_starve_cnt
  import arb_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                lose,
  input  logic                win,
  output logic [STARVE_W-1:0] count
);

  logic [STARVE_W-1:0] count_reg;

  // Any cycle that is not a loss (win, or LL idle) breaks the streak.
  always_ff @(posedge clk) begin
    if (rst || win || !lose) begin
      count_reg <= '0;
    end else if (count_reg != '1) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Writeback port arbiter: clears x1..x31 after reset, then grants pipeline or LL writes.
module rf_wb_arbiter
  import arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic           ARB_CLK,
  input  logic           ARB_RST,
  rf_wb_arbiter_if.slave bus
);

  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(NUM_REGS - 1);

  arb_state_t          state_reg;
  arb_state_t          state_next;
  logic [ADDR_W-1:0]   clr_cnt_reg;
  logic [ADDR_W-1:0]   clr_cnt_next;
  wb_word_t            wb_reg;
  wb_word_t            wb_next;
  logic [STARVE_W-1:0] starve_count;
  logic                clr_wrapped;
  logic                init_done;
  logic                run_ok;
  logic                starve_hit;
  logic                pipe_grant;
  logic                ll_grant;
  logic                ll_lose;

  // The counter wraps to 0 after address 31; that spare cycle hands over to RUN.
  assign clr_wrapped  = (clr_cnt_reg == '0);
  assign clr_cnt_next = (clr_cnt_reg == CLR_LAST) ? '0 : clr_cnt_reg + 1'b1;

  always_ff @(posedge ARB_CLK) begin
    if (ARB_RST) begin
      state_reg <= ST_INIT;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (state_reg == ST_INIT && clr_wrapped) begin
      state_next = ST_RUN;
    end
  end

  always_comb begin
    init_done  = (state_reg == ST_RUN);
    run_ok     = init_done && !ARB_RST;
    starve_hit = bus.LL_VALID && (starve_count == STARVE_W'(STARVE_MAX));
    pipe_grant = run_ok && bus.PIPE_VALID && !starve_hit;
    ll_grant   = run_ok && bus.LL_VALID && (starve_hit || !bus.PIPE_VALID);
    ll_lose    = run_ok && bus.LL_VALID && !ll_grant;
  end

  arb_starve_cnt u_starve_cnt (
    .clk   (ARB_CLK),
    .rst   (ARB_RST),
    .lose  (ll_lose),
    .win   (ll_grant),
    .count (starve_count)
  );

  always_comb begin
    wb_next = '0;
    if (state_reg == ST_INIT) begin
      if (!clr_wrapped) begin
        wb_next.en = 1'b1;
        wb_next.wa = clr_cnt_reg;
      end
    end else if (pipe_grant) begin
      wb_next = wb_write(bus.PIPE_WA, bus.PIPE_WD);
    end else if (ll_grant) begin
      wb_next = wb_write(bus.LL_WA, bus.LL_WD);
    end
  end

  always_ff @(posedge ARB_CLK) begin
    if (ARB_RST) begin
      wb_reg      <= '0;
      clr_cnt_reg <= ADDR_W'(1);
    end else begin
      wb_reg <= wb_next;
      if (state_reg == ST_INIT) begin
        clr_cnt_reg <= clr_cnt_next;
      end
    end
  end

  assign bus.PIPE_READY = pipe_grant;
  assign bus.LL_READY   = ll_grant;
  assign bus.WB_EN      = wb_reg.en;
  assign bus.WB_WA      = wb_reg.wa;
  assign bus.WB_WD      = wb_reg.wd;
  assign bus.INIT_DONE  = init_done;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter against a cycle-level behavioural model.
module tb_rf_wb_arbiter;
  import arb_pkg::*;

  localparam int SM = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rf_wb_arbiter_if bus();

  rf_wb_arbiter #(.STARVE_MAX(SM)) dut (
    .ARB_CLK (clk),
    .ARB_RST (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  logic        obs_pr, obs_lr, obs_done;
  logic [37:0] obs_wb;
  logic        exp_pr, exp_lr, exp_done;
  logic [37:0] exp_wb;

  bit m_run = 1'b0;
  int m_lost = 0;
  int m_init = 1;
  logic [31:0] rf_mdl [32];
  logic [31:0] rf_obs [32];

  // Drive one cycle of inputs, predict the outcome, capture what the DUT did.
  task automatic cycle(input logic r, input logic pv, input logic [4:0] pwa, input logic [31:0] pwd,
                       input logic lv, input logic [4:0] lwa, input logic [31:0] lwd);
    int g;
    @(negedge clk);
    rst = r;
    bus.PIPE_VALID = pv; bus.PIPE_WA = pwa; bus.PIPE_WD = pwd;
    bus.LL_VALID = lv;   bus.LL_WA = lwa;   bus.LL_WD = lwd;
    g = 0;
    if (!r && m_run) begin
      if (lv && m_lost == SM) g = 2;
      else if (pv) g = 1;
      else if (lv) g = 2;
    end
    exp_pr = (g == 1);
    exp_lr = (g == 2);
    exp_wb = '0;
    if (r) begin
      m_run = 1'b0; m_init = 1; m_lost = 0;
    end else if (!m_run) begin
      m_lost = 0;
      if (m_init <= 31) begin
        exp_wb = {1'b1, 5'(m_init), 32'h0};
        m_init++;
      end else begin
        m_run = 1'b1;
      end
    end else begin
      m_lost = (lv && g != 2) ? m_lost + 1 : 0;
      if (g == 1 && pwa != 0) exp_wb = {1'b1, pwa, pwd};
      else if (g == 2 && lwa != 0) exp_wb = {1'b1, lwa, lwd};
    end
    exp_done = m_run;
    if (exp_wb[37]) rf_mdl[exp_wb[36:32]] = exp_wb[31:0];
    #1;
    obs_pr = bus.PIPE_READY;
    obs_lr = bus.LL_READY;
    @(posedge clk);
    #1;
    obs_wb = {bus.WB_EN, bus.WB_WA, bus.WB_WD};
    obs_done = bus.INIT_DONE;
    if (obs_wb[37] === 1'b1) rf_obs[obs_wb[36:32]] = obs_wb[31:0];
    cyc++;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b1, 5'd3, 32'h1, 1'b1, 5'd4, 32'h2);
      n_total++;
      if ({obs_pr, obs_lr} !== 2'b00) $display("FAIL reset_ready cyc=%0d got=%b want=00", cyc, {obs_pr, obs_lr});
      else n_pass++;
      n_total++;
      if (obs_wb !== 38'h0 || obs_done !== 1'b0)
        $display("FAIL reset_out cyc=%0d got wb=%h done=%b want wb=0 done=0", cyc, obs_wb, obs_done);
      else n_pass++;
    end
  endtask

  task automatic test_init_clear();
    for (int i = 1; i <= 32; i++) begin
      cycle(1'b0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'haa);
      n_total++;
      if ({obs_pr, obs_lr} !== 2'b00) $display("FAIL init_ready i=%0d got=%b want=00", i, {obs_pr, obs_lr});
      else n_pass++;
      n_total++;
      if (i <= 31) begin
        if (obs_wb !== {1'b1, 5'(i), 32'h0} || obs_done !== 1'b0)
          $display("FAIL init_clear i=%0d got wb=%h done=%b want wb=%h done=0", i, obs_wb, obs_done, {1'b1, 5'(i), 32'h0});
        else n_pass++;
      end else begin
        if (obs_wb !== 38'h0 || obs_done !== 1'b1)
          $display("FAIL init_done i=%0d got wb=%h done=%b want wb=0 done=1", i, obs_wb, obs_done);
        else n_pass++;
      end
    end
  endtask

  task automatic test_pipe_basic();
    cycle(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    n_total++;
    if ({obs_pr, obs_lr} !== 2'b00 || obs_wb !== 38'h0)
      $display("FAIL idle cyc=%0d got rdy=%b wb=%h want rdy=00 wb=0", cyc, {obs_pr, obs_lr}, obs_wb);
    else n_pass++;
    cycle(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
    n_total++;
    if ({obs_pr, obs_lr} !== 2'b10) $display("FAIL pipe_ready cyc=%0d got=%b want=10", cyc, {obs_pr, obs_lr});
    else n_pass++;
    n_total++;
    if (obs_wb !== {1'b1, 5'd5, 32'hDEADBEEF}) $display("FAIL pipe_wb cyc=%0d got=%h want=%h", cyc, obs_wb, {1'b1, 5'd5, 32'hDEADBEEF});
    else n_pass++;
  endtask

  task automatic test_wa_zero();
    cycle(1'b0, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'h0);
    n_total++;
    if ({obs_pr, obs_lr} !== 2'b10) $display("FAIL wa0_ready cyc=%0d got=%b want=10", cyc, {obs_pr, obs_lr});
    else n_pass++;
    n_total++;
    if (obs_wb !== 38'h0) $display("FAIL wa0_wb cyc=%0d got=%h want=0", cyc, obs_wb);
    else n_pass++;
  endtask

  task automatic test_starve();
    logic ll_turn;
    cycle(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
      ll_turn = (k % (SM + 1) == SM);
      n_total++;
      if ({obs_pr, obs_lr} !== {~ll_turn, ll_turn})
        $display("FAIL starve_ready k=%0d got=%b want=%b", k, {obs_pr, obs_lr}, {~ll_turn, ll_turn});
      else n_pass++;
      n_total++;
      if (obs_wb !== (ll_turn ? {1'b1, 5'd4, 32'h44} : {1'b1, 5'd3, 32'h33}))
        $display("FAIL starve_wb k=%0d got=%h want_ll=%b", k, obs_wb, ll_turn);
      else n_pass++;
    end
  endtask

  task automatic test_same_addr();
    cycle(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    cycle(1'b0, 1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB);
    n_total++;
    if (obs_wb !== {1'b1, 5'd7, 32'hA}) $display("FAIL same_first cyc=%0d got=%h want=%h", cyc, obs_wb, {1'b1, 5'd7, 32'hA});
    else n_pass++;
    cycle(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hB);
    n_total++;
    if (obs_wb !== {1'b1, 5'd7, 32'hB}) $display("FAIL same_second cyc=%0d got=%h want=%h", cyc, obs_wb, {1'b1, 5'd7, 32'hB});
    else n_pass++;
    n_total++;
    if (rf_obs[7] !== 32'hB) $display("FAIL same_x7 got=%h want=0000000b", rf_obs[7]);
    else n_pass++;
  endtask

  task automatic test_random(input int n);
    logic pv = 1'b0, lv = 1'b0;
    logic [4:0] pwa = '0, lwa = '0;
    logic [31:0] pwd = '0, lwd = '0;
    for (int k = 0; k < n; k++) begin
      if (!pv) begin
        pv = ($urandom_range(0, 9) < 8);
        pwa = 5'($urandom_range(0, 31));
        pwd = $urandom;
      end
      if (!lv) begin
        lv = ($urandom_range(0, 9) < 6);
        lwa = 5'($urandom_range(0, 31));
        lwd = $urandom;
      end
      cycle(1'b0, pv, pwa, pwd, lv, lwa, lwd);
      n_total++;
      if ({obs_pr, obs_lr} !== {exp_pr, exp_lr})
        $display("FAIL rand_ready cyc=%0d got=%b want=%b", cyc, {obs_pr, obs_lr}, {exp_pr, exp_lr});
      else n_pass++;
      n_total++;
      if (obs_wb !== exp_wb || obs_done !== exp_done)
        $display("FAIL rand_wb cyc=%0d got wb=%h done=%b want wb=%h done=%b", cyc, obs_wb, obs_done, exp_wb, exp_done);
      else n_pass++;
      if (exp_pr) pv = 1'b0;
      if (exp_lr) lv = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 9; k++) cycle(1'b0, 1'b1, 5'd12, 32'h12, 1'b1, 5'd13, 32'h13);
    cycle(1'b1, 1'b1, 5'd12, 32'h12, 1'b1, 5'd13, 32'h13);
    n_total++;
    if ({obs_pr, obs_lr} !== 2'b00) $display("FAIL midrst_ready cyc=%0d got=%b want=00", cyc, {obs_pr, obs_lr});
    else n_pass++;
    n_total++;
    if (obs_wb !== 38'h0 || obs_done !== 1'b0)
      $display("FAIL midrst_out cyc=%0d got wb=%h done=%b want wb=0 done=0", cyc, obs_wb, obs_done);
    else n_pass++;
  endtask

  task automatic test_regfile();
    for (int r = 0; r < 32; r++) begin
      n_total++;
      if (rf_obs[r] !== rf_mdl[r]) $display("FAIL regfile x%0d got=%h want=%h", r, rf_obs[r], rf_mdl[r]);
      else n_pass++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    for (int r = 0; r < 32; r++) begin
      rf_mdl[r] = '0;
      rf_obs[r] = '0;
    end
    bus.PIPE_VALID = 1'b0; bus.PIPE_WA = '0; bus.PIPE_WD = '0;
    bus.LL_VALID = 1'b0;   bus.LL_WA = '0;   bus.LL_WD = '0;
    test_reset();
    test_init_clear();
    test_pipe_basic();
    test_wa_zero();
    test_starve();
    test_same_addr();
    test_random(300);
    test_reset_mid();
    test_init_clear();
    test_random(150);
    test_regfile();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
